// File: rtl/nes_controller_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : nes_controller_reader_if
// Brief    : Host/pad-side signal bundle of the NES controller reader.
// Revision : 1.0 - initial release
// ============================================================================
interface nes_controller_reader_if;
  logic       start_i;
  logic       nes_data_ni;
  logic       nes_latch_o;
  logic       nes_clk_o;
  logic [7:0] buttons_o;
  logic       valid_o;
  logic       busy_o;

  // master: the host/pad environment; slave: the reader itself
  modport master (
    output start_i,
    output nes_data_ni,
    input  nes_latch_o,
    input  nes_clk_o,
    input  buttons_o,
    input  valid_o,
    input  busy_o
  );

  modport slave (
    input  start_i,
    input  nes_data_ni,
    output nes_latch_o,
    output nes_clk_o,
    output buttons_o,
    output valid_o,
    output busy_o
  );
endinterface
`default_nettype wire

// File: rtl/nes_controller_reader.sv
`default_nettype none
// ============================================================================
// Module   : nes_controller_reader
// Brief    : Console-side NES pad reader; drives latch/shift clock and returns
//            the 8 buttons active-high, one frame per start or poll tick.
// Revision : 1.0 - initial release
// ============================================================================
module nes_controller_reader #(
  parameter int HALF_CYCLES = 8,
  parameter int POLL_CYCLES = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  nes_controller_reader_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              PH_W      = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [PH_W-1:0] C_PH_LAST = PH_W'(HALF_CYCLES - 1);
  localparam logic [4:0]      C_HC_LAST = 5'd17;

  logic [2:0]             state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [4:0]             hc_q, hc_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             buttons_q, buttons_d;
  logic                   latch_q, latch_d;
  logic                   nclk_q, nclk_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   poll_expire;
  logic                   trigger;
  logic                   sample;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= bus.nes_data_ni;
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.nes_data_ni};
      end
    end
  endgenerate

  // Free-running poll timer; its wrap is a trigger only if it lands while idle.
  generate
    if (POLL_CYCLES != 0) begin : g_poll
      localparam int                POLL_W      = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
      localparam logic [POLL_W-1:0] C_POLL_LAST = POLL_W'(POLL_CYCLES - 1);
      logic [POLL_W-1:0] poll_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    poll_q <= '0;
        else if (poll_q == C_POLL_LAST) poll_q <= '0;
        else                            poll_q <= poll_q + POLL_W'(1);
      end

      assign poll_expire = (poll_q == C_POLL_LAST);
    end else begin : g_no_poll
      assign poll_expire = 1'b0;
    end
  endgenerate

  assign trigger = bus.start_i | poll_expire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      hc_q      <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      hc_q      <= hc_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // A frame is 18 half-periods (hc) of H cycles (ph); hc 0..2 latch,
  // even hc >= 4 shift clock high, odd hc >= 3 shift clock low.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hc_d    = hc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        ph_d    = '0;
        hc_d    = '0;
        state_d = trigger ? S_LATCH : S_IDLE;
      end
      S_LATCH, S_LOW, S_HIGH: begin
        if (ph_q != C_PH_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else if (hc_q == C_HC_LAST) begin
          ph_d    = '0;
          hc_d    = '0;
          state_d = S_DONE;
        end else begin
          ph_d = '0;
          hc_d = hc_q + 5'd1;
          if (hc_d < 5'd3)   state_d = S_LATCH;
          else if (!hc_d[0]) state_d = S_HIGH;
          else               state_d = S_LOW;
        end
      end
      default: begin
        ph_d    = '0;
        hc_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Data is taken on the last cycle of every low half-period, just before the
  // next rising shift clock; A arrives first and ends up in bit 7.
  always_comb begin
    sample    = (state_q == S_LOW) && (ph_q == C_PH_LAST);
    shift_d   = sample ? {shift_q[6:0], sync_q[SYNC_STAGES-1]} : shift_q;
    latch_d   = (state_d == S_LATCH);
    nclk_d    = (state_d == S_HIGH) || ((state_d == S_LATCH) && (hc_d == 5'd1));
    busy_d    = (state_d == S_LATCH) || (state_d == S_LOW) || (state_d == S_HIGH);
    valid_d   = (state_d == S_DONE);
    buttons_d = (state_d == S_DONE) ? ~shift_d : buttons_q;
  end

  assign bus.nes_latch_o = latch_q;
  assign bus.nes_clk_o   = nclk_q;
  assign bus.buttons_o   = buttons_q;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_controller_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_controller_reader
// Brief    : Self-checking bench: frame-cycle reference model plus directed
//            frames against a behavioural NES pad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_controller_reader;
  localparam int H     = 4;
  localparam int FRAME = 18 * H;
  localparam int POLL  = 200;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   cyc    = 0;

  nes_controller_reader_if ifc0 ();
  nes_controller_reader_if ifc1 ();

  nes_controller_reader #(.HALF_CYCLES(H), .POLL_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc0)
  );

  nes_controller_reader #(.HALF_CYCLES(H), .POLL_CYCLES(POLL), .SYNC_STAGES(2)) dut1 (
    .clk_i (clk),
    .rst_ni(rst1_n),
    .bus   (ifc1)
  );

  always #5 clk = ~clk;

  // Behavioural pads: load on the rising clock while latch is high (sync
  // variant) or follow the buttons while latch is high (transparent variant).
  logic [7:0] pad0 = 8'h7E, pad1 = 8'h00, sr0 = 8'hFF, sr1 = 8'hFF;
  logic       sync_latch = 1'b1;
  logic       pclk0 = 1'b0, pclk1 = 1'b0;

  always @(ifc0.nes_clk_o, ifc0.nes_latch_o, pad0, sync_latch) begin
    if (ifc0.nes_clk_o && !pclk0) begin
      if (ifc0.nes_latch_o) sr0 = pad0;
      else                  sr0 = {sr0[6:0], 1'b1};
    end else if (ifc0.nes_latch_o && !sync_latch) begin
      sr0 = pad0;
    end
    pclk0 = ifc0.nes_clk_o;
  end

  always @(ifc1.nes_clk_o, ifc1.nes_latch_o) begin
    if (ifc1.nes_clk_o && !pclk1) begin
      if (ifc1.nes_latch_o) sr1 = pad1;
      else                  sr1 = {sr1[6:0], 1'b1};
    end
    pclk1 = ifc1.nes_clk_o;
  end

  assign ifc0.nes_data_ni = sr0[7];
  assign ifc1.nes_data_ni = sr1[7];

  // Reference model: m_f is the frame cycle (-1 idle, FRAME = done cycle).
  int         m_f   = -1;
  logic [7:0] m_btn = 8'h00;
  logic [7:0] m_exp = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_f   = -1;
      m_btn = 8'h00;
    end else begin
      if (m_f >= 0 && m_f < FRAME) m_f++;
      else if (ifc0.start_i) begin
        m_f   = 0;
        m_exp = ~pad0;
      end else m_f = -1;
      if (m_f == FRAME) m_btn = m_exp;
    end
  end

  function automatic bit exp_clk(input int f);
    if (f >= H && f < 2 * H) return 1'b1;
    if (f >= 4 * H && f < FRAME && ((f - 4 * H) % (2 * H)) < H) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic       e_l, e_c, e_b, e_v;
    logic [7:0] e_btn;
    if (!rst_n) begin
      {e_l, e_c, e_b, e_v} = 4'b0000;
      e_btn = 8'h00;
    end else begin
      e_l   = (m_f >= 0 && m_f < 3 * H);
      e_c   = (m_f >= 0) && exp_clk(m_f);
      e_b   = (m_f >= 0 && m_f < FRAME);
      e_v   = (m_f == FRAME);
      e_btn = m_btn;
    end
    n_vec++;
    if ({ifc0.nes_latch_o, ifc0.nes_clk_o, ifc0.busy_o, ifc0.valid_o, ifc0.buttons_o} !==
        {e_l, e_c, e_b, e_v, e_btn}) begin
      n_err++;
      $display("FAIL cycle_compare @%0t: got latch=%b clk=%b busy=%b valid=%b btn=%h, expected latch=%b clk=%b busy=%b valid=%b btn=%h",
               $time, ifc0.nes_latch_o, ifc0.nes_clk_o, ifc0.busy_o, ifc0.valid_o, ifc0.buttons_o,
               e_l, e_c, e_b, e_v, e_btn);
    end
  end

  // Per-frame waveform statistics of dut0, indexed by frame cycle.
  int   sf = 0, s_lat = 0, s_busy = 0, s_rise = 0, s_r0 = -1, s_r1 = -1, s_prev = -1, s_to_valid = 0;
  bit   s_space_ok = 1'b1;
  logic p_busy = 1'b0, p_nclk = 1'b0;

  always @(negedge clk) begin
    if (ifc0.busy_o && !p_busy) begin
      sf = 0; s_lat = 0; s_busy = 0; s_rise = 0;
      s_r0 = -1; s_r1 = -1; s_prev = -1; s_space_ok = 1'b1;
    end
    if (ifc0.busy_o) begin
      if (ifc0.nes_latch_o) s_lat++;
      s_busy++;
      if (ifc0.nes_clk_o && !p_nclk) begin
        s_rise++;
        if (s_r0 < 0)                  s_r0 = sf;
        else if (s_r1 < 0)             s_r1 = sf;
        else if (sf - s_prev != 2 * H) s_space_ok = 1'b0;
        s_prev = sf;
      end
      sf++;
    end
    if (ifc0.valid_o) s_to_valid = sf + 1;
    p_busy = ifc0.busy_o;
    p_nclk = ifc0.nes_clk_o;
  end

  // Polled instance: frames every POLL cycles, buttons alternating FF/00.
  int         v1_count = 0, v1_prev = -1;
  logic [7:0] e1 = 8'hFF;

  always @(negedge clk) begin
    if (rst1_n && ifc1.valid_o) begin
      n_vec++;
      if (ifc1.buttons_o !== e1) begin
        n_err++;
        $display("FAIL poll_buttons: got %h expected %h", ifc1.buttons_o, e1);
      end
      if (v1_prev >= 0) begin
        n_vec++;
        if (cyc - v1_prev != POLL) begin
          n_err++;
          $display("FAIL poll_period: got %0d expected %0d", cyc - v1_prev, POLL);
        end
      end
      v1_prev = cyc;
      v1_count++;
      pad1 = ~pad1;
      e1   = ~e1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 ifc0.start_i = 1'b1;
    @(posedge clk); #1 ifc0.start_i = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (ifc0.valid_o) begin
        at = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_valid: got timeout expected valid_o within 300 cycles");
  endtask

  task automatic wait_frame_cycle(input int f);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (m_f == f) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_frame_cycle: got timeout expected frame cycle %0d", f);
  endtask

  task automatic check_frame(input logic [7:0] exp_btn);
    check("buttons",        ifc0.buttons_o, exp_btn);
    check("latch_cycles",   s_lat, 12);
    check("busy_cycles",    s_busy, 72);
    check("clk_rises",      s_rise, 8);
    check("first_rise_f",   s_r0, 4);
    check("second_rise_f",  s_r1, 16);
    check("rise_spacing",   s_space_ok, 1);
    check("trigger_to_valid", s_to_valid, 73);
  endtask

  initial begin
    int t0, t1, t2;
    ifc0.start_i = 1'b0;
    ifc1.start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_state", {ifc0.nes_latch_o, ifc0.nes_clk_o, ifc0.busy_o, ifc0.valid_o, ifc0.buttons_o}, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    // sync-latch pad
    pulse_start();
    wait_valid(t0);
    check_frame(8'h81);

    // transparent-latch pad
    sync_latch = 1'b0;
    pad0 = 8'h5A;
    pulse_start();
    wait_valid(t0);
    check_frame(8'hA5);
    pad0 = 8'h7E;
    pulse_start();
    wait_valid(t0);
    check_frame(8'h81);
    sync_latch = 1'b1;

    // start held high: back-to-back frames
    @(posedge clk); #1 ifc0.start_i = 1'b1;
    wait_valid(t0);
    wait_valid(t1);
    wait_valid(t2);
    ifc0.start_i = 1'b0;
    check("b2b_period_1", t1 - t0, 73);
    check("b2b_period_2", t2 - t1, 73);
    check_frame(8'h81);

    // mid-frame start is ignored and not queued
    pulse_start();
    wait_frame_cycle(20);
    ifc0.start_i = 1'b1;
    @(posedge clk); #1 ifc0.start_i = 1'b0;
    wait_valid(t0);
    check_frame(8'h81);
    repeat (5) @(negedge clk);
    #1;
    check("no_queued_frame", ifc0.busy_o, 0);

    // asynchronous reset mid-frame, then a clean frame
    pad0 = 8'h00;
    pulse_start();
    wait_frame_cycle(30);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {ifc0.nes_latch_o, ifc0.nes_clk_o, ifc0.busy_o, ifc0.buttons_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    wait_valid(t0);
    check_frame(8'hFF);

    for (int i = 0; i < 1500 && v1_count < 4; i++) @(negedge clk);
    check("poll_frames_seen", (v1_count >= 4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
